// File: rtl/amer_put_ctrl_if.sv
// Host-side register bus for amer_put_ctrl: parameter word writes, run request and result handshake.
// master = host driving the bus, slave = the controller.
interface amer_put_ctrl_if;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cmd_go;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] result_out;

  modport master (
    output wr_en, wr_addr, wr_data, cmd_go, res_ready,
    input  busy, res_valid, result_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, cmd_go, res_ready,
    output busy, res_valid, result_out
  );
endinterface

// File: rtl/amer_put_ctrl.sv
// Host-side sequencer for the American-put engine: loads parameters, pulses start_s1/start_s2, captures the result.
// Optional cycle counter output run_cycles is enabled by defining AMER_PUT_CTRL_CYCLE_COUNT_EN.
module amer_put_ctrl #(
  parameter int unsigned INIT_CYCLES = 64,
  parameter int unsigned RUN_CYCLES  = 4000
) (
  input  logic               clk,
  input  logic               rst,
  amer_put_ctrl_if.slave     host,
  output logic [63:0]        p_up,
  output logic [63:0]        p_down,
  output logic [63:0]        log_lambda_up,
  output logic [63:0]        log_lambda_down,
  output logic [63:0]        K_over_S,
  output logic               start_s1,
  output logic               start_s2,
  input  logic [63:0]        eng_result
`ifdef AMER_PUT_CTRL_CYCLE_COUNT_EN
  ,
  output logic [31:0]        run_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, S1, INIT, S2, RUN, CAPT, HOLD} state_t;

  localparam logic [23:0] INIT_LOAD = 24'(INIT_CYCLES - 1);
  localparam logic [23:0] RUN_LOAD  = 24'(RUN_CYCLES - 1);
  localparam int unsigned NUM_PARAMS = 5;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        res_valid_q, res_valid_d;
  logic [63:0] result_q, result_d;
  logic        start_s1_q, start_s1_d;
  logic        start_s2_q, start_s2_d;
  logic        param_wr;
  logic [63:0] param_out [NUM_PARAMS];

  assign param_wr = (state_q == IDLE) && host.wr_en;

  // Each parameter owns an even/odd word-address pair; addresses 10..15 match nothing.
  for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_param
    localparam logic [3:0] LO_ADDR = 4'(2 * gi);
    localparam logic [3:0] HI_ADDR = 4'(2 * gi + 1);
    logic [63:0] param_q, param_d;

    always_comb begin
      param_d = param_q;
      if (param_wr && host.wr_addr == LO_ADDR) param_d[31:0]  = host.wr_data;
      if (param_wr && host.wr_addr == HI_ADDR) param_d[63:32] = host.wr_data;
    end

    always_ff @(posedge clk) begin
      if (rst) param_q <= '0;
      else     param_q <= param_d;
    end

    assign param_out[gi] = param_q;
  end

  assign p_up            = param_out[0];
  assign p_down          = param_out[1];
  assign log_lambda_up   = param_out[2];
  assign log_lambda_down = param_out[3];
  assign K_over_S        = param_out[4];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    res_valid_d = res_valid_q;
    result_d    = result_q;
    start_s1_d  = 1'b0;
    start_s2_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (host.cmd_go) begin
          state_d    = S1;
          busy_d     = 1'b1;
          start_s1_d = 1'b1;
        end
      end
      S1: begin
        cnt_d   = INIT_LOAD;
        state_d = INIT;
      end
      INIT: begin
        if (cnt_q == '0) begin
          state_d    = S2;
          start_s2_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      S2: begin
        cnt_d = RUN_LOAD;
        if (RUN_CYCLES == 1) state_d = CAPT;
        else                 state_d = RUN;
      end
      // Leave one count early so the CAPT cycle itself is the last of the RUN_CYCLES window.
      RUN: begin
        cnt_d = cnt_q - 24'd1;
        if (cnt_q == 24'd1) state_d = CAPT;
      end
      CAPT: begin
        result_d    = eng_result;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (host.res_ready) begin
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      start_s1_q  <= 1'b0;
      start_s2_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      start_s1_q  <= start_s1_d;
      start_s2_q  <= start_s2_d;
    end
  end

  assign start_s1        = start_s1_q;
  assign start_s2        = start_s2_q;
  assign host.busy       = busy_q;
  assign host.res_valid  = res_valid_q;
  assign host.result_out = result_q;

`ifdef AMER_PUT_CTRL_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  // Starts at 1 so the accepting cycle is included in the count.
  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (state_q == IDLE && host.cmd_go)
      cyc_cnt_d = 32'd1;
    else if (state_q != IDLE && state_q != HOLD && cyc_cnt_q != 32'hFFFF_FFFF)
      cyc_cnt_d = cyc_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cyc_cnt_q <= '0;
    else     cyc_cnt_q <= cyc_cnt_d;
  end

  assign run_cycles = cyc_cnt_q;
`endif

endmodule
